// File: rtl/mem_lsu_axi.sv
// rtl/mem_lsu_axi.sv - MEM-stage load/store unit driving a single-outstanding AXI4-Lite master
//
// Purpose: runs the load/store held in EX/MEM as one AXI4-Lite transaction,
// stalls the pipeline while it is in flight and returns the extended load result.
//
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   req_valid/we/funct3/addr/wdata   memory-access fields from EX/MEM
//   stall_en                 freezes EX/MEM and upstream stages
//   load_data/load_valid/fault       registered results, valid in DONE only
//   AW*/W*/B*/AR*/R*         AXI4-Lite master channels
module mem_lsu_axi #(
    parameter int ADDR_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall_en,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              fault,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [31:0]       WDATA,
    output logic [3:0]        WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [31:0]       RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RD_A  = 3'd3;
    localparam logic [2:0] S_RD_D  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q, fault_d;

    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;

    logic        req_illegal;
    logic        req_misalign;
    logic        aw_fire;
    logic        w_fire;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    // Request legality is judged on the live EX/MEM fields in IDLE.
    always_comb begin
        if (req_we) begin
            req_illegal = (req_funct3 >= 3'b011);
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        case (req_funct3[1:0])
            2'b01:   req_misalign = req_addr[0];
            2'b10:   req_misalign = (req_addr[1:0] != 2'b00);
            default: req_misalign = 1'b0;
        endcase
    end

    // Load extract: bring the addressed lane down to bit 0, then extend.
    assign rd_shift = RDATA >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  rd_ext = RDATA;
            3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
            3'b101:  rd_ext = {16'd0, rd_shift[15:0]};
            default: rd_ext = 32'd0;
        endcase
    end

    // Store lanes: narrow data is replicated so any strobe position sees it.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << addr_q[1:0];
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    assign aw_fire = AWVALID & AWREADY;
    assign w_fire  = WVALID & WREADY;

    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (req_illegal || req_misalign) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                        if (!req_we) begin
                            load_data_d = 32'd0;
                        end
                    end else begin
                        state_d = req_we ? S_WR : S_RD_A;
                    end
                end
            end
            S_WR: begin
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (BVALID) begin
                    state_d = S_DONE;
                    fault_d = (BRESP != 2'b00);
                end
            end
            S_RD_A: begin
                if (ARREADY) begin
                    state_d = S_RD_D;
                end
            end
            S_RD_D: begin
                if (RVALID) begin
                    state_d = S_DONE;
                    if (RRESP != 2'b00) begin
                        fault_d     = 1'b1;
                        load_data_d = 32'd0;
                    end else begin
                        load_data_d  = rd_ext;
                        load_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= S_IDLE;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
        end else if (state_q == S_IDLE && req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
        end
    end

    // Channel outputs are decoded from state so reset clears them at once.
    assign stall_en   = ((state_q == S_IDLE) && req_valid) || (state_q == S_WR) ||
                        (state_q == S_WRESP) || (state_q == S_RD_A) || (state_q == S_RD_D);
    assign AWVALID    = (state_q == S_WR) && !aw_done_q;
    assign WVALID     = (state_q == S_WR) && !w_done_q;
    assign AWADDR     = (state_q == S_WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign WDATA      = (state_q == S_WR) ? st_data : 32'd0;
    assign WSTRB      = (state_q == S_WR) ? st_strb : 4'd0;
    assign BREADY     = (state_q == S_WRESP);
    assign ARVALID    = (state_q == S_RD_A);
    assign ARADDR     = (state_q == S_RD_A) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign RREADY     = (state_q == S_RD_D);
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign fault      = fault_q;

endmodule
